rs_chien_folded: RTL and testbench

Folded, parametrised Chien search for the RS decoder. It evaluates the error-locator polynomial Λ(x) at α^i for i = 0..SYMB_NUM-2, PAR positions per clock, and returns the error-position bitmap, root count and a decode-failure flag. It sits between the Berlekamp-Massey stage and the Forney/correction stage. PAR trades area against latency; PAR = SYMB_NUM-1 gives a 1-cycle fully parallel search.

---
 rtl/gf_pkg.sv | 57 +++++
 rtl/rs_chien_eval_lane.sv | 28 ++
 rtl/rs_chien_folded.sv | 132 +++++++++++++
 tb/tb_rs_chien_folded.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// GF(2^8) arithmetic shared by the RS decoder stages.
// Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
// Provides the code geometry (SYMB_WIDTH, SYMB_NUM, T_LEN) and
// constant-multiplier helpers. All helpers are meant to be called with
// a constant alpha exponent, so each one folds to a fixed XOR network.
// It also provides the Chien-search FSM state type.
package gf_pkg;

    localparam int unsigned SYMB_WIDTH = 8;
    localparam int unsigned SYMB_NUM   = 256;
    localparam int unsigned T_LEN      = 8;
    localparam logic [SYMB_WIDTH-1:0] GF_POLY_LO = 8'h1D;

    typedef logic [SYMB_WIDTH-1:0] symb_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        OUTPUT
    } chien_state_e;

    // Multiply by alpha: shift left and reduce.
    function automatic symb_t gf_xtime(symb_t a);
        return {a[SYMB_WIDTH-2:0], 1'b0} ^ (a[SYMB_WIDTH-1] ? GF_POLY_LO : '0);
    endfunction

    // alpha^k as a field symbol; the exponent wraps modulo SYMB_NUM-1.
    function automatic symb_t alpha_to_symb(int unsigned k);
        symb_t r;
        r = symb_t'(1);
        for (int unsigned n = 0; n < k % (SYMB_NUM - 1); n++) begin
            r = gf_xtime(r);
        end
        return r;
    endfunction

    // a * b, where b is expected to be a constant.
    function automatic symb_t gf_mult_symb(symb_t a, symb_t b);
        symb_t p;
        symb_t s;
        p = '0;
        s = a;
        for (int i = 0; i < int'(SYMB_WIDTH); i++) begin
            if (b[i]) begin
                p = p ^ s;
            end
            s = gf_xtime(s);
        end
        return p;
    endfunction

    // a * alpha^k.
    function automatic symb_t gf_mult_const(symb_t a, int unsigned k);
        return gf_mult_symb(a, alpha_to_symb(k));
    endfunction

endpackage

// File: rtl/rs_chien_eval_lane.sv
// One Chien-search lane: o_eval = XOR_j i_terms[j] * alpha^(LANE*j).
// Ports:
//   i_terms  current term vector (term_j = Lambda_j * alpha^(beat*PAR*j))
//   o_eval   Lambda evaluated at the position this lane covers
module rs_chien_eval_lane
    import gf_pkg::*;
#(
    parameter int unsigned LANE = 0
) (
    input  logic [T_LEN:0][SYMB_WIDTH-1:0] i_terms,
    output logic [SYMB_WIDTH-1:0]          o_eval
);

    logic [T_LEN:0][SYMB_WIDTH-1:0] w_prod;

    for (genvar j = 0; j <= int'(T_LEN); j++) begin : g_term
        localparam symb_t ALPHA_KJ = alpha_to_symb(LANE * j);
        assign w_prod[j] = gf_mult_symb(i_terms[j], ALPHA_KJ);
    end

    always_comb begin
        o_eval = '0;
        for (int j = 0; j <= int'(T_LEN); j++) begin
            o_eval = o_eval ^ w_prod[j];
        end
    end

endmodule

// File: rtl/rs_chien_folded.sv
// Folded Chien search: evaluates Lambda(alpha^i), i = 0..SYMB_NUM-2,
// PAR positions per clock, then presents the root bitmap, root count
// and a decode-failure flag (root count != deg Lambda).
// Ports:
//   aclk, aresetn             clock, async active-low reset
//   i_error_locator[_vld]     Lambda coefficients (index j = x^j), valid
//   o_error_locator_rdy       high only in IDLE (and never in reset)
//   o_error_positions         bit SYMB_NUM-2-i set iff Lambda(alpha^i) = 0
//   o_error_cnt               number of roots found
//   o_decode_fail             o_error_cnt != deg(Lambda)
//   o_error_positions_vld     high only in OUTPUT
//   i_error_positions_rdy     output backpressure
module rs_chien_folded
    import gf_pkg::*;
#(
    parameter int unsigned PAR = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [T_LEN:0][SYMB_WIDTH-1:0] i_error_locator,
    input  logic                           i_error_locator_vld,
    output logic                           o_error_locator_rdy,
    output logic [SYMB_NUM-2:0]            o_error_positions,
    output logic [SYMB_WIDTH-1:0]          o_error_cnt,
    output logic                           o_decode_fail,
    output logic                           o_error_positions_vld,
    input  logic                           i_error_positions_rdy
);

    localparam int unsigned NBEATS = (SYMB_NUM - 1 + PAR - 1) / PAR;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned IDX_W  = $clog2(SYMB_NUM - 1);

    chien_state_e                   r_state;
    logic [T_LEN:0][SYMB_WIDTH-1:0] r_terms;
    logic [SYMB_WIDTH-1:0]          r_deg;
    logic [SYMB_WIDTH-1:0]          r_cnt;
    logic [SYMB_NUM-2:0]            r_bitmap;
    logic [BEAT_W-1:0]              r_beat;
    logic                           r_fail;

    logic [PAR-1:0][SYMB_WIDTH-1:0] w_eval;
    logic [SYMB_NUM-2:0]            w_bitmap_nxt;
    logic [SYMB_WIDTH-1:0]          w_cnt_nxt;
    logic [SYMB_WIDTH-1:0]          w_deg;

    for (genvar k = 0; k < int'(PAR); k++) begin : g_lane
        rs_chien_eval_lane #(
            .LANE(k)
        ) u_lane (
            .i_terms(r_terms),
            .o_eval (w_eval[k])
        );
    end

    // Degree of the incoming locator: highest nonzero coefficient.
    always_comb begin
        w_deg = '0;
        for (int j = 0; j <= int'(T_LEN); j++) begin
            if (i_error_locator[j] != '0) begin
                w_deg = SYMB_WIDTH'(j);
            end
        end
    end

    // Merge this beat's roots; lanes past the last position are masked.
    always_comb begin
        w_bitmap_nxt = r_bitmap;
        w_cnt_nxt    = r_cnt;
        for (int k = 0; k < int'(PAR); k++) begin
            int pos;
            pos = int'(r_beat) * int'(PAR) + k;
            if (pos <= int'(SYMB_NUM) - 2 && w_eval[k] == '0) begin
                w_bitmap_nxt[IDX_W'(int'(SYMB_NUM) - 2 - pos)] = 1'b1;
                w_cnt_nxt = w_cnt_nxt + SYMB_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= IDLE;
            r_terms  <= '0;
            r_deg    <= '0;
            r_cnt    <= '0;
            r_bitmap <= '0;
            r_beat   <= '0;
            r_fail   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_error_locator_vld) begin
                        r_terms  <= i_error_locator;
                        r_deg    <= w_deg;
                        r_cnt    <= '0;
                        r_bitmap <= '0;
                        r_fail   <= 1'b0;
                        r_beat   <= '0;
                        r_state  <= SEARCH;
                    end
                end
                SEARCH: begin
                    r_bitmap <= w_bitmap_nxt;
                    r_cnt    <= w_cnt_nxt;
                    // Advance every term by PAR positions.
                    for (int j = 0; j <= int'(T_LEN); j++) begin
                        r_terms[j] <= gf_mult_const(r_terms[j], PAR * j);
                    end
                    if (r_beat == BEAT_W'(NBEATS - 1)) begin
                        r_fail  <= (w_cnt_nxt != r_deg);
                        r_state <= OUTPUT;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                OUTPUT: begin
                    if (i_error_positions_rdy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_error_locator_rdy   = aresetn && (r_state == IDLE);
    assign o_error_positions_vld = (r_state == OUTPUT);
    assign o_error_positions     = r_bitmap;
    assign o_error_cnt           = r_cnt;
    assign o_decode_fail         = r_fail;

endmodule

// File: tb/tb_rs_chien_folded.sv
// Bench for rs_chien_folded: a PAR=16 instance (dut 0) and a PAR=255
// instance (dut 1). Expected results come from a direct Horner
// evaluation of Lambda at every alpha^i, queued at accept time and
// popped when the DUT presents its output.
module tb_rs_chien_folded;
    import gf_pkg::T_LEN;

    typedef logic [T_LEN:0][7:0] loc_t;
    typedef struct packed {
        logic [254:0] bm;
        logic [7:0]   cnt;
        logic         fail;
    } exp_t;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    loc_t         loc = '0;
    logic         vld_a = 1'b0, vld_b = 1'b0;
    logic         rdy_a, rdy_b;
    logic [254:0] pos_a, pos_b;
    logic [7:0]   cnt_a, cnt_b;
    logic         fail_a, fail_b;
    logic         ovld_a, ovld_b;
    logic         ordy_a = 1'b1, ordy_b = 1'b1;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 aclk = ~aclk;

    rs_chien_folded #(.PAR(16)) u_dut_a (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .i_error_locator      (loc),
        .i_error_locator_vld  (vld_a),
        .o_error_locator_rdy  (rdy_a),
        .o_error_positions    (pos_a),
        .o_error_cnt          (cnt_a),
        .o_decode_fail        (fail_a),
        .o_error_positions_vld(ovld_a),
        .i_error_positions_rdy(ordy_a)
    );

    rs_chien_folded #(.PAR(255)) u_dut_b (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .i_error_locator      (loc),
        .i_error_locator_vld  (vld_b),
        .o_error_locator_rdy  (rdy_b),
        .o_error_positions    (pos_b),
        .o_error_cnt          (cnt_b),
        .o_decode_fail        (fail_b),
        .o_error_positions_vld(ovld_b),
        .i_error_positions_rdy(ordy_b)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference field arithmetic (0x11D).
    function automatic logic [7:0] b_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] b_alpha(int k);
        logic [7:0] r = 8'h01;
        for (int n = 0; n < k % 255; n++) r = b_mul(r, 8'h02);
        return r;
    endfunction

    function automatic exp_t model(loc_t l);
        exp_t e;
        int deg = 0;
        e = '0;
        for (int j = 0; j <= T_LEN; j++) if (l[j] != 0) deg = j;
        for (int i = 0; i < 255; i++) begin
            logic [7:0] x = b_alpha(i);
            logic [7:0] acc = '0;
            for (int j = T_LEN; j >= 0; j--) acc = b_mul(acc, x) ^ l[j];
            if (acc == 0) begin
                e.bm[254 - i] = 1'b1;
                e.cnt = e.cnt + 8'd1;
            end
        end
        e.fail = (int'(e.cnt) != deg);
        return e;
    endfunction

    // Product of (1 + alpha^e x) over n distinct random exponents.
    task automatic mk_random(input int n, output loc_t l);
        int used[$];
        l = '0;
        l[0] = 8'h01;
        while (used.size() < n) begin
            int ex = $urandom_range(0, 254);
            int dup = 0;
            foreach (used[u]) if (used[u] == ex) dup = 1;
            if (dup == 0) begin
                used.push_back(ex);
                for (int j = T_LEN; j >= 1; j--) l[j] = l[j] ^ b_mul(b_alpha(ex), l[j-1]);
            end
        end
    endtask

    function automatic logic g_rdy(int d);   return d == 0 ? rdy_a  : rdy_b;  endfunction
    function automatic logic g_ovld(int d);  return d == 0 ? ovld_a : ovld_b; endfunction
    function automatic logic [254:0] g_pos(int d); return d == 0 ? pos_a : pos_b; endfunction
    function automatic logic [7:0] g_cnt(int d);   return d == 0 ? cnt_a : cnt_b; endfunction
    function automatic logic g_fail(int d);  return d == 0 ? fail_a : fail_b; endfunction

    task automatic set_vld(input int d, input logic v);
        if (d == 0) vld_a = v; else vld_b = v;
    endtask

    task automatic set_ordy(input int d, input logic v);
        if (d == 0) ordy_a = v; else ordy_b = v;
    endtask

    // Wait for input ready, push one locator, wait for the result and
    // check it (optionally with the output held off for 'hold' cycles).
    task automatic run_case(input string tag, input loc_t l, input int d, input int hold);
        int   n;
        exp_t e;
        set_ordy(d, hold == 0);
        @(negedge aclk);
        n = 0;
        while (!g_rdy(d) && n < 400) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "/in_rdy"}, g_rdy(d), 1);
        loc = l;
        set_vld(d, 1'b1);
        sb_q.push_back(model(l));
        @(negedge aclk);
        set_vld(d, 1'b0);
        n = 0;
        while (!g_ovld(d) && n < 400) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "/latency"}, n, (d == 0) ? 16 : 1);
        for (int h = 0; h < hold; h++) begin
            check({tag, "/hold_vld"}, g_ovld(d), 1);
            check({tag, "/hold_in_rdy"}, g_rdy(d), 0);
            check({tag, "/hold_bm"}, g_pos(d), sb_q[0].bm);
            check({tag, "/hold_cnt"}, g_cnt(d), sb_q[0].cnt);
            @(negedge aclk);
        end
        set_ordy(d, 1'b1);
        if (sb_q.size() == 0) begin
            check({tag, "/sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "/vld"}, g_ovld(d), 1);
            check({tag, "/bitmap"}, g_pos(d), e.bm);
            check({tag, "/cnt"}, g_cnt(d), e.cnt);
            check({tag, "/fail"}, g_fail(d), e.fail);
        end
        @(negedge aclk);
        check({tag, "/vld_drop"}, g_ovld(d), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        loc_t l;
        repeat (3) @(negedge aclk);
        check("rst/in_rdy", rdy_a, 0);
        check("rst/vld", ovld_a, 0);
        check("rst/bitmap", pos_a, 0);
        check("rst/cnt", cnt_a, 0);
        check("rst/fail", fail_a, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst/in_rdy", rdy_a, 1);

        l = '0; l[0] = 8'h01;
        run_case("c1_const1", l, 0, 0);
        l = '0; l[0] = 8'h01; l[1] = b_alpha(254);
        run_case("c2_root1", l, 0, 0);
        l = '0; l[0] = 8'h01; l[1] = 8'h01 ^ b_alpha(250); l[2] = b_alpha(250);
        run_case("c3_root0_5", l, 0, 0);
        l = '0; l[0] = 8'h01; l[1] = b_alpha(1);
        run_case("c4_root254", l, 0, 0);
        l = '0; l[0] = 8'h01; l[2] = 8'h01;
        run_case("c5_double", l, 0, 0);
        l = '0;
        run_case("c6_zero", l, 0, 0);
        l = '0; l[0] = 8'h07;
        run_case("c7_const7", l, 0, 0);
        mk_random(8, l);
        run_case("c8_rand8", l, 0, 0);
        mk_random(3, l);
        run_case("c9_rand3", l, 0, 0);
        l = '0; l[0] = 8'h01; l[1] = 8'h01 ^ b_alpha(250); l[2] = b_alpha(250);
        run_case("c10_hold", l, 0, 5);

        // Reset in the middle of a search.
        @(negedge aclk);
        loc = l;
        vld_a = 1'b1;
        @(negedge aclk);
        vld_a = 1'b0;
        repeat (7) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("midrst/vld", ovld_a, 0);
        check("midrst/bitmap", pos_a, 0);
        check("midrst/cnt", cnt_a, 0);
        check("midrst/in_rdy", rdy_a, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        l = '0; l[0] = 8'h01; l[1] = b_alpha(254);
        run_case("c11_after_rst", l, 0, 0);

        l = '0; l[0] = 8'h01; l[1] = 8'h01 ^ b_alpha(250); l[2] = b_alpha(250);
        run_case("p255_c3", l, 1, 0);
        l = '0; l[0] = 8'h01; l[1] = b_alpha(1);
        run_case("p255_c4", l, 1, 0);
        mk_random(6, l);
        run_case("p255_rand6", l, 1, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
